// File: rtl/flash_audio_reader.sv
// Flash-to-audio playback engine: fetches 32-bit flash words over Avalon-MM and
// emits two 8-bit samples per word, one per sample_tick, forward or reverse.
module flash_audio_reader #(
  parameter logic [22:0] END_ADDR = 23'h7FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        count_forward,
  input  logic        reset_address,
  input  logic        sample_tick,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [7:0]  audio_data,
  output logic        audio_valid
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, TICK_A, TICK_B, ADVANCE
  } state_t;

  state_t      state, state_nxt;
  logic [22:0] addr_nxt;
  logic        read_nxt;
  logic [15:0] word, word_nxt;
  logic        dir, dir_nxt;
  logic [7:0]  data_nxt;
  logic        valid_nxt;
  logic        reset_pending, pend_nxt;
  logic        accept, restart;
  logic [22:0] reload;
  logic [7:0]  first_sample, second_sample;
  logic        unused_bytes;

  assign flash_mem_byteenable = 4'b1111;
  assign unused_bytes = ^{flash_mem_readdata[23:16], flash_mem_readdata[7:0]};

  // word holds {readdata[31:24], readdata[15:8]}; the other bytes are never played
  assign first_sample  = dir ? word[7:0]  : word[15:8];
  assign second_sample = dir ? word[15:8] : word[7:0];
  assign reload        = count_forward ? '0 : END_ADDR;

  always_comb begin
    state_nxt = state;
    addr_nxt  = flash_mem_address;
    read_nxt  = flash_mem_read;
    word_nxt  = word;
    dir_nxt   = dir;
    data_nxt  = audio_data;
    valid_nxt = 1'b0;
    pend_nxt  = reset_pending;
    accept    = 1'b0;
    restart   = 1'b0;

    case (state)
      IDLE: begin
        if (reset_address) restart = 1'b1;
        state_nxt = FETCH;
        read_nxt  = 1'b1;
      end
      FETCH: begin
        if (reset_address) pend_nxt = 1'b1;
        if (!flash_mem_waitrequest) begin
          read_nxt  = 1'b0;
          state_nxt = WAIT_DATA;
          accept    = flash_mem_readdatavalid;
        end
      end
      WAIT_DATA: begin
        if (reset_address) pend_nxt = 1'b1;
        accept = flash_mem_readdatavalid;
      end
      TICK_A: begin
        if (reset_address) begin
          restart = 1'b1;
        end else if (sample_tick && play) begin
          data_nxt  = first_sample;
          valid_nxt = 1'b1;
          state_nxt = TICK_B;
        end
      end
      TICK_B: begin
        if (reset_address) begin
          restart = 1'b1;
        end else if (sample_tick && play) begin
          data_nxt  = second_sample;
          valid_nxt = 1'b1;
          state_nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        if (reset_address) begin
          restart = 1'b1;
        end else begin
          if (count_forward)
            addr_nxt = (flash_mem_address == END_ADDR) ? '0 : flash_mem_address + 23'd1;
          else
            addr_nxt = (flash_mem_address == '0) ? END_ADDR : flash_mem_address - 23'd1;
          state_nxt = FETCH;
          read_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A completed read with a pending (or coincident) restart discards its word
    if (accept) begin
      if (reset_pending || reset_address) begin
        restart = 1'b1;
      end else begin
        word_nxt  = {flash_mem_readdata[31:24], flash_mem_readdata[15:8]};
        dir_nxt   = count_forward;
        state_nxt = TICK_A;
      end
    end

    if (restart) begin
      addr_nxt  = reload;
      pend_nxt  = 1'b0;
      state_nxt = FETCH;
      read_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      flash_mem_address <= '0;
      flash_mem_read    <= 1'b0;
      word              <= '0;
      dir               <= 1'b1;
      audio_data        <= '0;
      audio_valid       <= 1'b0;
      reset_pending     <= 1'b0;
    end else begin
      state             <= state_nxt;
      flash_mem_address <= addr_nxt;
      flash_mem_read    <= read_nxt;
      word              <= word_nxt;
      dir               <= dir_nxt;
      audio_data        <= data_nxt;
      audio_valid       <= valid_nxt;
      reset_pending     <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_flash_audio_reader.sv
// Directed bench for flash_audio_reader with a behavioural Avalon flash slave
// whose wait states and read latency are set per phase.
module tb_flash_audio_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        count_forward = 1'b1;
  logic        reset_address = 1'b0;
  logic        sample_tick = 1'b0;
  logic        read;
  logic [22:0] addr;
  logic [3:0]  byteenable;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = '0;
  logic        rdv = 1'b0;
  logic [7:0]  audio_data;
  logic        audio_valid;

  int unsigned wait_cycles = 0;
  int unsigned lat = 0;
  int unsigned pend = 0;
  int unsigned wcnt = 0;
  logic [22:0] pend_addr = '0;
  int unsigned acc_count = 0;
  logic [22:0] last_addr = '1;

  int unsigned rd_cycles = 0;
  int unsigned unstable = 0;
  int unsigned vcount = 0;
  logic        prev_read = 1'b0;
  logic [22:0] prev_addr = '0;

  int tests = 0;
  int failed = 0;

  flash_audio_reader #(.END_ADDR(23'h7FFFF)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .play                   (play),
    .count_forward          (count_forward),
    .reset_address          (reset_address),
    .sample_tick            (sample_tick),
    .flash_mem_read         (read),
    .flash_mem_address      (addr),
    .flash_mem_byteenable   (byteenable),
    .flash_mem_waitrequest  (waitreq),
    .flash_mem_readdata     (rdata),
    .flash_mem_readdatavalid(rdv),
    .audio_data             (audio_data),
    .audio_valid            (audio_valid)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [22:0] a);
    case (a)
      23'h000000: mem = 32'hAABBCCDD;
      23'h000001: mem = 32'h11223344;
      23'h7FFFF:  mem = 32'h55667788;
      default:    mem = 32'h01020304;
    endcase
  endfunction

  // Flash slave: decisions made on the falling edge, sampled by the DUT on the rising edge
  always @(negedge clk) begin
    if (!reset_n) begin
      waitreq = 1'b0; rdv = 1'b0; rdata = '0; pend = 0; wcnt = 0;
    end else begin
      rdv = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin rdv = 1'b1; rdata = mem(pend_addr); end
      end
      if (read) begin
        if (wcnt < wait_cycles) begin
          waitreq = 1'b1; wcnt++;
        end else begin
          waitreq = 1'b0; wcnt = 0; acc_count++; last_addr = addr;
          if (lat == 0) begin rdv = 1'b1; rdata = mem(addr); end
          else begin pend = lat; pend_addr = addr; end
        end
      end else begin
        waitreq = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (read) rd_cycles++;
    if (read && prev_read && addr != prev_addr) unstable++;
    prev_read = read;
    prev_addr = addr;
    if (audio_valid) vcount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) nstep();
  endtask

  task automatic tick_raw();
    nstep();
    sample_tick = 1'b1;
    nstep();
    sample_tick = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input logic exp_valid, input logic [7:0] exp_data);
    tick_raw();
    check({tag, "_valid"}, {31'd0, audio_valid}, {31'd0, exp_valid});
    check({tag, "_data"}, {24'd0, audio_data}, {24'd0, exp_data});
    if (exp_valid) begin
      nstep();
      check({tag, "_pulse"}, {31'd0, audio_valid}, 32'd0);
    end
  endtask

  task automatic do_reset(input logic cf);
    reset_n = 1'b0;
    count_forward = cf;
    idle(2);
    reset_n = 1'b1;
  endtask

  int unsigned acc0, rd0, un0, v0;

  initial begin
    // Paused playback after reset
    wait_cycles = 0; lat = 0; play = 1'b0;
    acc0 = acc_count;
    reset_n = 1'b0;
    idle(2);
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_addr", {9'd0, addr}, 32'd0);
    check("rst_data", {24'd0, audio_data}, 32'd0);
    check("rst_valid", {31'd0, audio_valid}, 32'd0);
    check("byteenable", {28'd0, byteenable}, 32'hF);
    reset_n = 1'b1;
    idle(5);
    check("first_acc", acc_count - acc0, 32'd1);
    check("first_addr", {9'd0, last_addr}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick_chk("paused", 1'b0, 8'h00);
      idle(2);
    end
    check("paused_acc", acc_count - acc0, 32'd1);

    // Forward playback, zero-latency slave
    play = 1'b1;
    tick_chk("fwd_a", 1'b1, 8'hCC);
    tick_chk("fwd_b", 1'b1, 8'hAA);
    idle(10);
    check("fwd_next_addr", {9'd0, last_addr}, 32'd1);
    check("fwd_acc", acc_count - acc0, 32'd2);
    tick_chk("fwd_w1a", 1'b1, 8'h33);

    // Reverse from reset, wrap 0 -> END, then forward wrap END -> 0
    lat = 1;
    do_reset(1'b0);
    idle(6);
    tick_chk("rev_a", 1'b1, 8'hAA);
    tick_chk("rev_b", 1'b1, 8'hCC);
    idle(10);
    check("rev_wrap_addr", {9'd0, last_addr}, 32'h7FFFF);
    count_forward = 1'b1;
    tick_chk("end_a", 1'b1, 8'h55);
    tick_chk("end_b", 1'b1, 8'h77);
    idle(10);
    check("fwd_wrap_addr", {9'd0, last_addr}, 32'd0);
    tick_chk("wrap_w0a", 1'b1, 8'hCC);

    // Walk forward to 0x100, then restart while its read is outstanding
    lat = 4;
    do_reset(1'b1);
    idle(8);
    for (int i = 0; i < 512; i++) begin
      tick_raw();
      if (i != 511) idle(8);
    end
    for (int k = 0; k < 50 && last_addr != 23'h000100; k++) nstep();
    check("walk_addr", {9'd0, last_addr}, 32'h100);
    nstep();
    acc0 = acc_count;
    v0 = vcount;
    reset_address = 1'b1;
    nstep();
    reset_address = 1'b0;
    idle(12);
    check("rstwait_valid", vcount - v0, 32'd0);
    check("rstwait_addr", {9'd0, last_addr}, 32'd0);
    check("rstwait_acc", acc_count - acc0, 32'd1);
    tick_chk("rstwait_w0a", 1'b1, 8'hCC);

    // Restart coinciding with a tick: no sample, refetch from 0
    acc0 = acc_count;
    nstep();
    sample_tick = 1'b1;
    reset_address = 1'b1;
    nstep();
    sample_tick = 1'b0;
    reset_address = 1'b0;
    check("rsttick_valid", {31'd0, audio_valid}, 32'd0);
    check("rsttick_data", {24'd0, audio_data}, 32'hCC);
    idle(10);
    check("rsttick_addr", {9'd0, last_addr}, 32'd0);
    check("rsttick_acc", acc_count - acc0, 32'd1);
    tick_chk("rsttick_w0a", 1'b1, 8'hCC);

    // Five wait states on the next fetch
    wait_cycles = 5; lat = 2;
    acc0 = acc_count; rd0 = rd_cycles; un0 = unstable;
    tick_chk("ws_w0b", 1'b1, 8'hAA);
    idle(20);
    check("ws_read_cycles", rd_cycles - rd0, 32'd6);
    check("ws_addr_stable", unstable - un0, 32'd0);
    check("ws_acc", acc_count - acc0, 32'd1);
    check("ws_addr", {9'd0, last_addr}, 32'd1);
    tick_chk("ws_w1a", 1'b1, 8'h33);
    tick_chk("ws_w1b", 1'b1, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/flash_audio_reader.md
# flash_audio_reader

Playback engine consuming the keyboard controller's `play`, `count_forward` and `reset_address` commands. Fetches 32-bit words from the on-board flash over an Avalon-MM read-master port, splits each word into two 8-bit audio samples, and presents one sample per `sample_tick` to the audio output path. Sits between the keyboard/iPod controller and the audio DAC interface, with `sample_tick` supplied by the sample-rate clock divider.

## Interface
- `END_ADDR`, 23'h7FFFF: last valid flash word address; the address range is 0..END_ADDR inclusive.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `play`  in  1  level; 1 = emit samples, 0 = paused.
- `count_forward`  in  1  level; 1 = address increments, 0 = address decrements.
- `reset_address`  in  1  one-cycle pulse; restart from the beginning of the song.
- `sample_tick`  in  1  one-cycle strobe at the audio sample rate.
- `flash_mem_read`  out  1  Avalon read request.
- `flash_mem_address`  out  23  word address.
- `flash_mem_byteenable`  out  4  constant 4'b1111.
- `flash_mem_waitrequest`  in  1  slave stall.
- `flash_mem_readdata`  in  32  read data.
- `flash_mem_readdatavalid`  in  1  read data qualifier.
- `audio_data`  out  8  current sample, two's complement.
- `audio_valid`  out  1  one-cycle pulse when `audio_data` updates.

## Operation
- States: IDLE, FETCH, WAIT_DATA, TICK_A, TICK_B, ADVANCE.
- IDLE: reset state. Moves to FETCH on the next clock.
- FETCH: `flash_mem_read`=1 with `flash_mem_address` held stable. Moves to WAIT_DATA on the first edge where `waitrequest`=0.
- WAIT_DATA: waits for `readdatavalid`. A `readdatavalid` arriving in the same cycle FETCH is accepted is honoured. On acceptance: latch the word, latch `count_forward` as the word direction `dir`, go to TICK_A.
- Sample order:
  - `dir`=1: first sample = `readdata[15:8]`, second = `readdata[31:24]`.
  - `dir`=0: order reversed.
- TICK_A: on `sample_tick` with `play`=1, output the first sample and go to TICK_B.
- TICK_B: on `sample_tick` with `play`=1, output the second sample and go to ADVANCE.
- Pause: with `play`=0, TICK_A and TICK_B ignore ticks and hold. An in-flight read always completes.
- ADVANCE (one cycle):
  - `count_forward`=1: address+1, wrapping END_ADDR→0.
  - `count_forward`=0: address−1, wrapping 0→END_ADDR.
  - Then go to FETCH.
  - `count_forward` is sampled here. A direction change therefore takes effect on the next word.
- `reset_address` in IDLE, TICK_A, TICK_B or ADVANCE: load address = 0 if `count_forward`=1, else END_ADDR. Go to FETCH with no sample output. This overrides the ADVANCE increment.
- `reset_address` in FETCH or WAIT_DATA:
  - Set `reset_pending`. The bus transaction completes normally and the word is discarded.
  - Apply the reset load and go to FETCH.
  - `reset_pending` clears at that point.
- `reset_address` coinciding with `sample_tick` in TICK_A/TICK_B: the reset wins and no `audio_valid` is produced.
- Address arithmetic is 23-bit; wrap is explicit against END_ADDR, not natural overflow.

## Timing
- Reset values: `flash_mem_read`=0, `flash_mem_address`=0, `audio_data`=8'h00, `audio_valid`=0, `reset_pending`=0, `dir`=1, state IDLE.
- All outputs are registered except `flash_mem_byteenable`.
- `flash_mem_read` rises 1 cycle after reset release (IDLE→FETCH). It stays high until the cycle `waitrequest`=0 is sampled and drops on the following edge.
- `audio_data` and `audio_valid` update on the edge after the accepting `sample_tick`. `audio_valid` is high for exactly 1 cycle. `audio_data` holds until the next update.
- Word-to-word overhead: ADVANCE (1) + FETCH (≥1) + flash latency. This must complete between TICK_B and the next tick, which is guaranteed at the 22 kHz rate.
- Asserting `reset_n` mid-transaction abandons the read immediately. The flash slave is reset by the same signal.

## Test plan
- Reset, `play`=0, slave returns 32'hAABBCCDD for address 0 → one read at address 0, then ten ticks produce no `audio_valid` and `audio_data` stays 8'h00.
- `play`=1, `count_forward`=1, same word → `audio_data` 8'hCC then 8'hAA on successive ticks, then `flash_mem_read` at address 1.
- `count_forward`=0 from reset → word 0 gives 8'hAA then 8'hCC, then the next read is at address 23'h7FFFF.
- Forward from address END_ADDR → the read after its two samples is at address 0.
- `reset_address` pulse during WAIT_DATA at address 23'h000100, `count_forward`=1 → that word yields no `audio_valid` and the next read is at address 0.
- `waitrequest` held high 5 cycles → `flash_mem_read` and `flash_mem_address` stay stable for 6 cycles, with exactly one transaction accepted and one word consumed.
